vga_frame_scanner: RTL and testbench

- Produces the 640x480@60 Hz pixel stream consumed by the edge-detection stage and by the VGA output pins.
- Generates raster timing and issues reads to the 320x240 12-bit camera frame buffer (2x upscale).
- Emits xAddr/yAddr, sync and a pixel word, all realigned to the buffer's read latency.
- Sits between the frame-buffer BRAM read port and the downstream pixel-processing chain.

---
 rtl/vga_frame_scanner.sv | 138 +++++++++++++
 tb/tb_vga_frame_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_scanner.sv
// 640x480@60 raster generator that reads a 2x-upscaled 320x240 12-bit frame buffer
// and realigns timing to its read latency. Optional colour bars: `define TEST_PATTERN_EN.
`timescale 1ns/1ps
module vga_frame_scanner #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FB_WIDTH   = 320,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk25,
  input  logic        resetN,
  input  logic [11:0] fbData,
  input  logic        testPattern,
  output logic [16:0] fbAddr,
  output logic        fbRdEn,
  output logic [9:0]  xAddr,
  output logic [9:0]  yAddr,
  output logic [11:0] pixelOut,
  output logic        pixelValid,
  output logic        hSync,
  output logic        vSync,
  output logic        frameStart
);

  localparam int D       = RD_LATENCY + 2;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [16:0] FB_W   = 17'(FB_WIDTH);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        active_c, hs_c, vs_c;
  logic [16:0] addr_c;
  logic [16:0] fb_addr_q;
  logic        fb_rd_q;
  // Index k holds the counter-derived value from k clocks ago; index D drives the pins.
  logic [D:1]       vld_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [D:1][9:0]  x_pipe_q, y_pipe_q;
  logic [11:0] pix_src, pix_q;
  logic        fs_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    active_c = (h_q < H_ACT) && (v_q < V_ACT);
    hs_c     = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_c     = !((v_q >= VS_BEG) && (v_q < VS_END));
    // 2x upscale: each buffer pixel covers a 2x2 block of screen pixels.
    addr_c   = ({8'd0, v_q[9:1]} * FB_W) + {8'd0, h_q[9:1]};
  end

`ifdef TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0] bar_c;

  always_comb begin
    bar_c   = x_pipe_q[D-1] / BAR_W;
    pix_src = fbData;
    if (testPattern) begin
      case (bar_c)
        10'd0:   pix_src = 12'hFFF;
        10'd1:   pix_src = 12'hFF0;
        10'd2:   pix_src = 12'h0FF;
        10'd3:   pix_src = 12'h0F0;
        10'd4:   pix_src = 12'hF0F;
        10'd5:   pix_src = 12'hF00;
        10'd6:   pix_src = 12'h00F;
        default: pix_src = 12'h000;
      endcase
    end
  end
`else
  logic unused_test_pattern;
  assign unused_test_pattern = testPattern;
  assign pix_src = fbData;
`endif

  always_ff @(posedge clk25 or negedge resetN) begin
    if (!resetN) begin
      h_q        <= '0;
      v_q        <= '0;
      fb_rd_q    <= 1'b0;
      fb_addr_q  <= '0;
      vld_pipe_q <= '0;
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
      x_pipe_q   <= '0;
      y_pipe_q   <= '0;
      pix_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      fb_rd_q    <= active_c;
      fb_addr_q  <= active_c ? addr_c : '0;
      vld_pipe_q <= {vld_pipe_q[D-1:1], active_c};
      hs_pipe_q  <= {hs_pipe_q[D-1:1], hs_c};
      vs_pipe_q  <= {vs_pipe_q[D-1:1], vs_c};
      x_pipe_q   <= {x_pipe_q[D-1:1], h_q};
      y_pipe_q   <= {y_pipe_q[D-1:1], v_q};
      // fbData for the stage D-1 pixel arrives now; capture it alongside the final stage.
      pix_q      <= vld_pipe_q[D-1] ? pix_src : '0;
      fs_q       <= vld_pipe_q[D-1] && (x_pipe_q[D-1] == '0) && (y_pipe_q[D-1] == '0);
    end
  end

  assign fbAddr     = fb_addr_q;
  assign fbRdEn     = fb_rd_q;
  assign xAddr      = x_pipe_q[D];
  assign yAddr      = y_pipe_q[D];
  assign pixelOut   = pix_q;
  assign pixelValid = vld_pipe_q[D];
  assign hSync      = hs_pipe_q[D];
  assign vSync      = vs_pipe_q[D];
  assign frameStart = fs_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a default-timing instance plus a shrunken-timing instance
// (RD_LATENCY=3) so whole frames fit in a short run; both checked against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_frame_scanner;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, fbw, rl;
  } tim_t;

  localparam logic [53:0] RSTV = {1'b0, 17'd0, 10'd0, 10'd0, 12'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 1};
  tim_t TB = '{64, 4, 8, 4, 48, 2, 2, 3, 32, 3};

  logic clk = 1'b0, resetN = 1'b0, testPattern = 1'b0;
  logic [11:0] key = 12'h000;
  bit force_f = 1'b0;
  int m, n_chk = 0, n_pass = 0;

  logic [16:0] a_fbAddr, b_fbAddr;
  logic        a_fbRdEn, b_fbRdEn, a_pv, b_pv, a_hs, b_hs, a_vs, b_vs, a_fs, b_fs;
  logic [9:0]  a_x, a_y, b_x, b_y;
  logic [11:0] a_pix, b_pix, a_fbData, mb0, mb1, mb2;
  logic [53:0] obsA, obsB, expA, expB;

  always #20 clk = ~clk;

  vga_frame_scanner dut_a (
    .clk25(clk), .resetN(resetN), .fbData(a_fbData), .testPattern(testPattern),
    .fbAddr(a_fbAddr), .fbRdEn(a_fbRdEn), .xAddr(a_x), .yAddr(a_y), .pixelOut(a_pix),
    .pixelValid(a_pv), .hSync(a_hs), .vSync(a_vs), .frameStart(a_fs));

  vga_frame_scanner #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2),
                      .V_SYNC(2), .V_BP(3), .FB_WIDTH(32), .RD_LATENCY(3)) dut_b (
    .clk25(clk), .resetN(resetN), .fbData(mb2), .testPattern(testPattern),
    .fbAddr(b_fbAddr), .fbRdEn(b_fbRdEn), .xAddr(b_x), .yAddr(b_y), .pixelOut(b_pix),
    .pixelValid(b_pv), .hSync(b_hs), .vSync(b_vs), .frameStart(b_fs));

  assign obsA = {a_fbRdEn, a_fbAddr, a_x, a_y, a_pix, a_pv, a_hs, a_vs, a_fs};
  assign obsB = {b_fbRdEn, b_fbAddr, b_x, b_y, b_pix, b_pv, b_hs, b_vs, b_fs};

  // Frame-buffer contents: low address bits scrambled by key, or all-white when forced.
  function automatic logic [11:0] mem_rd(input logic [11:0] a);
    return force_f ? 12'hFFF : (a ^ key);
  endfunction

  always @(posedge clk) begin
    a_fbData <= mem_rd(a_fbAddr[11:0]);
    mb0 <= mem_rd(b_fbAddr[11:0]);
    mb1 <= mb0;
    mb2 <= mb1;
  end

  // Clock edges since reset release; the counters show raster position m during cycle m.
  always @(posedge clk or negedge resetN)
    if (!resetN) m <= 0;
    else         m <= m + 1;

  function automatic logic [11:0] bar_rgb(input int b);
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return bars[b];
  endfunction

  function automatic logic [53:0] model(input tim_t t, input int mm, input bit tp);
    int ht, vt, d, p, h, v;
    logic rd; logic [16:0] fa, pa; logic [9:0] x, y; logic [11:0] px;
    logic pv, hs, vs, fs;
    ht = t.ha + t.hfp + t.hs + t.hbp;
    vt = t.va + t.vfp + t.vs + t.vbp;
    d  = t.rl + 2;
    rd = 1'b0; fa = '0;
    if (mm >= 1) begin
      p = mm - 1; h = p % ht; v = (p / ht) % vt;
      if (h < t.ha && v < t.va) begin
        rd = 1'b1;
        fa = 17'((v / 2) * t.fbw + h / 2);
      end
    end
    x = '0; y = '0; px = '0; pv = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
    if (mm >= d) begin
      p = mm - d; h = p % ht; v = (p / ht) % vt;
      x  = 10'(h); y = 10'(v);
      pv = (h < t.ha) && (v < t.va);
      hs = !(h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hs);
      vs = !(v >= t.va + t.vfp && v < t.va + t.vfp + t.vs);
      fs = (h == 0) && (v == 0);
      if (pv) begin
        pa = 17'((v / 2) * t.fbw + h / 2);
        px = mem_rd(pa[11:0]);
`ifdef TEST_PATTERN_EN
        if (tp) px = bar_rgb(h / (t.ha / 8));
`else
        if (tp && 1'b0) px = bar_rgb(0);
`endif
      end
    end
    return {rd, fa, x, y, px, pv, hs, vs, fs};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    expA = model(TA, m, testPattern);
    expB = model(TB, m, testPattern);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (obsA !== RSTV) $display("FAIL reset_A got %h want %h", obsA, RSTV); else n_pass++;
    n_chk++; if (obsB !== RSTV) $display("FAIL reset_B got %h want %h", obsB, RSTV); else n_pass++;
    resetN = 1'b1;
    #1;
    n_chk++; if (obsA !== RSTV) $display("FAIL release_A got %h want %h", obsA, RSTV); else n_pass++;
  endtask

  task automatic test_scan();
    int nf = 0, fsA = 0, pvA = 0, hsA = 0, vsA = 0, fsB = 0, pvB = 0, hsB = 0, vsB = 0;
    int firstPvA = -1, firstFsA = -1, firstHsA = -1, firstPvB = -1;
    bit seen = 1'b0; logic [11:0] pix53 = '0;
    key = 12'h000; force_f = 1'b0; testPattern = 1'b0;
    do_reset();
    for (int i = 0; i < 8810; i++) begin
`ifndef TEST_PATTERN_EN
      testPattern = 1'($urandom);
`endif
      tick();
      n_chk++; if (obsA !== expA) begin nf++; $display("FAIL scan_A m=%0d got %h want %h", m, obsA, expA); end else n_pass++;
      n_chk++; if (obsB !== expB) begin nf++; $display("FAIL scan_B m=%0d got %h want %h", m, obsB, expB); end else n_pass++;
      if (m >= 3 && m < 4003) begin fsA += int'(a_fs); pvA += int'(a_pv); hsA += int'(!a_hs); vsA += int'(!a_vs); end
      if (m >= 5 && m < 4405) begin fsB += int'(b_fs); pvB += int'(b_pv); hsB += int'(!b_hs); vsB += int'(!b_vs); end
      if (firstPvA < 0 && a_pv)  firstPvA = m;
      if (firstFsA < 0 && a_fs)  firstFsA = m;
      if (firstHsA < 0 && !a_hs) firstHsA = m;
      if (firstPvB < 0 && b_pv)  firstPvB = m;
      if (!seen && a_pv && a_x == 10'd5 && a_y == 10'd3) begin seen = 1'b1; pix53 = a_pix; end
      if (nf > 20) break;
    end
    n_chk++; if (fsB != 1)    $display("FAIL frame_fs_B got %0d want 1", fsB); else n_pass++;
    n_chk++; if (pvB != 3072) $display("FAIL frame_pv_B got %0d want 3072", pvB); else n_pass++;
    n_chk++; if (hsB != 440)  $display("FAIL frame_hs_B got %0d want 440", hsB); else n_pass++;
    n_chk++; if (vsB != 160)  $display("FAIL frame_vs_B got %0d want 160", vsB); else n_pass++;
    n_chk++; if (fsA != 1)    $display("FAIL lines_fs_A got %0d want 1", fsA); else n_pass++;
    n_chk++; if (pvA != 3200) $display("FAIL lines_pv_A got %0d want 3200", pvA); else n_pass++;
    n_chk++; if (hsA != 480)  $display("FAIL lines_hs_A got %0d want 480", hsA); else n_pass++;
    n_chk++; if (vsA != 0)    $display("FAIL lines_vs_A got %0d want 0", vsA); else n_pass++;
    n_chk++; if (firstPvA != 3)   $display("FAIL lat_pv_A got %0d want 3", firstPvA); else n_pass++;
    n_chk++; if (firstFsA != 3)   $display("FAIL lat_fs_A got %0d want 3", firstFsA); else n_pass++;
    n_chk++; if (firstHsA != 659) $display("FAIL lat_hs_A got %0d want 659", firstHsA); else n_pass++;
    n_chk++; if (firstPvB != 5)   $display("FAIL lat_pv_B got %0d want 5", firstPvB); else n_pass++;
    n_chk++; if (!seen || pix53 !== 12'h142) $display("FAIL pix_5_3 got %h seen %0d want 142", pix53, seen); else n_pass++;
  endtask

  task automatic test_blank_fff();
    int nf = 0;
    force_f = 1'b1; testPattern = 1'b0;
    do_reset();
    for (int i = 0; i < 4410; i++) begin
      tick();
      if (!a_pv) begin
        n_chk++; if (a_pix !== 12'h000) begin nf++; $display("FAIL blank_A m=%0d got %h want 000", m, a_pix); end else n_pass++;
      end
      if (!b_pv) begin
        n_chk++; if (b_pix !== 12'h000) begin nf++; $display("FAIL blank_B m=%0d got %h want 000", m, b_pix); end else n_pass++;
      end
      n_chk++; if (obsB !== expB) begin nf++; $display("FAIL fff_B m=%0d got %h want %h", m, obsB, expB); end else n_pass++;
      if (nf > 20) break;
    end
    force_f = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int nf = 0, firstFsA = -1, firstFsB = -1;
    key = 12'($urandom);
    do_reset();
    // Run until dut_a's counters sit at hCount=300, vCount=10.
    while (m < 8300 && nf <= 20) begin
      tick();
      n_chk++; if (obsA !== expA) begin nf++; $display("FAIL pre_A m=%0d got %h want %h", m, obsA, expA); end else n_pass++;
    end
    #5 resetN = 1'b0;
    #1;
    n_chk++; if (obsA !== RSTV) $display("FAIL async_rst_A got %h want %h", obsA, RSTV); else n_pass++;
    n_chk++; if (obsB !== RSTV) $display("FAIL async_rst_B got %h want %h", obsB, RSTV); else n_pass++;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 1700; i++) begin
      tick();
      n_chk++; if (obsA !== expA) begin nf++; $display("FAIL post_A m=%0d got %h want %h", m, obsA, expA); end else n_pass++;
      n_chk++; if (obsB !== expB) begin nf++; $display("FAIL post_B m=%0d got %h want %h", m, obsB, expB); end else n_pass++;
      if (firstFsA < 0 && a_fs) firstFsA = m;
      if (firstFsB < 0 && b_fs) firstFsB = m;
      if (nf > 20) break;
    end
    n_chk++; if (firstFsA != 3) $display("FAIL restart_fs_A got %0d want 3", firstFsA); else n_pass++;
    n_chk++; if (firstFsB != 5) $display("FAIL restart_fs_B got %0d want 5", firstFsB); else n_pass++;
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int nf = 0;
    key = 12'($urandom); testPattern = 1'b1;
    do_reset();
    for (int i = 0; i < 1700; i++) begin
      tick();
      n_chk++; if (obsA !== expA) begin nf++; $display("FAIL tp_A m=%0d got %h want %h", m, obsA, expA); end else n_pass++;
      if (a_pv && a_x < 10'd80) begin
        n_chk++; if (a_pix !== 12'hFFF) begin nf++; $display("FAIL tp_bar0 x=%0d got %h want FFF", a_x, a_pix); end else n_pass++;
      end
      if (a_pv && a_x == 10'd80) begin
        n_chk++; if (a_pix !== 12'hFF0) begin nf++; $display("FAIL tp_x80 got %h want FF0", a_pix); end else n_pass++;
      end
      if (a_pv && a_x == 10'd639) begin
        n_chk++; if (a_pix !== 12'h000) begin nf++; $display("FAIL tp_x639 got %h want 000", a_pix); end else n_pass++;
      end
      if (!a_pv) begin
        n_chk++; if (a_pix !== 12'h000) begin nf++; $display("FAIL tp_blank m=%0d got %h want 000", m, a_pix); end else n_pass++;
      end
      if (nf > 20) break;
    end
    testPattern = 1'b0;
  endtask
`else
  task automatic test_pattern();
    int nf = 0;
    key = 12'($urandom);
    do_reset();
    for (int i = 0; i < 1700; i++) begin
      testPattern = 1'($urandom);
      tick();
      n_chk++; if (obsA !== expA) begin nf++; $display("FAIL tp_ignored_A m=%0d got %h want %h", m, obsA, expA); end else n_pass++;
      n_chk++; if (obsB !== expB) begin nf++; $display("FAIL tp_ignored_B m=%0d got %h want %h", m, obsB, expB); end else n_pass++;
      if (nf > 20) break;
    end
    testPattern = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_blank_fff();
    test_midframe_reset();
    test_pattern();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
